// File: rtl/l4_drain_pkg.sv
// cnn_pkg: constants and types shared by the layer-4 drain slice.
//   L4_LANES / L4_ROWS / CNN_DW : geometry of one layer-4 result set
//   drain_state_t               : drain controller states
package cnn_pkg;

  localparam int unsigned L4_LANES = 16;
  localparam int unsigned L4_ROWS  = 4;
  localparam int unsigned CNN_DW   = 18;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAP,
    SEND,
    DONE
  } drain_state_t;

endpackage

// File: rtl/l4_drain_if.sv
// l4_drain_if: valid/ready result stream from l4_drain to the next layer.
//   dout    : streamed result word
//   vld     : dout valid
//   sof/eof : with vld, first / last word of a result set
//   out_rdy : consumer accepts the word when vld & out_rdy
// Modports: master (drain side), slave (consumer side).
interface l4_drain_if #(
  parameter int unsigned DW = 18
);
  logic [DW-1:0] dout;
  logic          vld;
  logic          sof;
  logic          eof;
  logic          out_rdy;

  modport master (output dout, vld, sof, eof, input out_rdy);
  modport slave  (input dout, vld, sof, eof, output out_rdy);
endinterface

// File: rtl/l4_drain_buf.sv
// l4_drain_buf: ROWS x LANES capture buffer for one layer-4 result set.
//   clk, rst_n : clock, async active-low reset (read register only)
//   wr_en      : write one full row (wr_row) from wr_data
//   rd_en      : load rd_data with word rd_addr ({row, lane}) on the next edge
// The storage array itself is not reset. LANES must be a power of two.
module l4_drain_buf #(
  parameter int unsigned DW    = 18,
  parameter int unsigned LANES = 16,
  parameter int unsigned ROWS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(ROWS)-1:0]       wr_row,
  input  logic [DW-1:0]                 wr_data [LANES-1:0],
  input  logic                          rd_en,
  input  logic [$clog2(ROWS*LANES)-1:0] rd_addr,
  output logic [DW-1:0]                 rd_data
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned IW = $clog2(ROWS*LANES);

  logic [DW-1:0] mem [ROWS][LANES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        mem[wr_row][l] <= wr_data[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr[IW-1:LW]][rd_addr[LW-1:0]];
    end
  end

endmodule

// File: rtl/l4_drain.sv
// l4_drain: read-side partner of the layer-4 FC block. On a rising l4_rdy it
// captures ROWS rows of LANES results, streams them one word at a time over
// strm, then pulses tx_done so layer 4 can start the next image.
//   clk, rst_n : clock, async active-low reset
//   l4_rdy     : layer-4 results ready (level, held until tx_done)
//   l4_dout    : current layer-4 row
//   tx_done    : one-cycle pulse after the last word is accepted
//   strm       : output stream (master modport)
// Optional (macro L4_DRAIN_ARGMAX_EN): max_idx / max_val / max_vld report the
// unsigned argmax of the captured set, lowest index winning ties.
module l4_drain
  import cnn_pkg::*;
#(
  parameter int unsigned DW     = CNN_DW,
  parameter int unsigned LANES  = L4_LANES,
  parameter int unsigned ROWS   = L4_ROWS,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          l4_rdy,
  input  logic [DW-1:0]                 l4_dout [LANES-1:0],
  output logic                          tx_done,
`ifdef L4_DRAIN_ARGMAX_EN
  output logic [$clog2(ROWS*LANES)-1:0] max_idx,
  output logic [DW-1:0]                 max_val,
  output logic                          max_vld,
`endif
  l4_drain_if.master                    strm
);
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned LW       = $clog2(LANES);
  localparam int unsigned IW       = $clog2(ROWS*LANES);
  localparam int unsigned LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int unsigned LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  drain_state_t     state;
  logic             rdy_q;
  logic             rise;
  logic [RW-1:0]    row_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [IW-1:0]    idx;
  logic             load;
  logic             cap_wr;

  assign rise   = l4_rdy & ~rdy_q;
  assign cap_wr = (state == CAP) && l4_rdy;
  // Fetch the next word whenever the output register is empty or is being
  // consumed this edge; the final accept (eof) ends the stream instead.
  assign load   = (state == SEND) && (!strm.vld || (strm.out_rdy && !strm.eof));

  l4_drain_buf #(
    .DW    (DW),
    .LANES (LANES),
    .ROWS  (ROWS)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_wr),
    .wr_row  (row_cnt),
    .wr_data (l4_dout),
    .rd_en   (load),
    .rd_addr (idx),
    .rd_data (strm.dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      row_cnt  <= '0;
      lat_cnt  <= '0;
      idx      <= '0;
      tx_done  <= 1'b0;
      strm.vld <= 1'b0;
      strm.sof <= 1'b0;
      strm.eof <= 1'b0;
    end else begin
      rdy_q   <= l4_rdy;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          row_cnt <= '0;
          lat_cnt <= '0;
          if (rise) state <= (RD_LAT > 1) ? WAIT : CAP;
        end
        WAIT: begin
          if (!l4_rdy)                          state <= IDLE;
          else if (lat_cnt == LAT_W'(LAT_LAST)) state <= CAP;
          else                                  lat_cnt <= lat_cnt + 1'b1;
        end
        CAP: begin
          if (!l4_rdy) begin
            state <= IDLE;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == RW'(ROWS - 1)) begin
              state <= SEND;
              idx   <= '0;
            end
          end
        end
        SEND: begin
          if (load) begin
            strm.vld <= 1'b1;
            strm.sof <= (idx == '0);
            strm.eof <= (idx == IW'(ROWS*LANES - 1));
            idx      <= idx + 1'b1;
          end else if (strm.vld && strm.out_rdy && strm.eof) begin
            strm.vld <= 1'b0;
            strm.sof <= 1'b0;
            strm.eof <= 1'b0;
            tx_done  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L4_DRAIN_ARGMAX_EN
  logic [DW-1:0] row_max_val;
  logic [LW-1:0] row_max_lane;

  // Strict compare from lane 0 upward keeps the lowest lane on ties.
  always_comb begin
    row_max_val  = l4_dout[0];
    row_max_lane = '0;
    for (int unsigned l = 1; l < LANES; l++) begin
      if (l4_dout[l] > row_max_val) begin
        row_max_val  = l4_dout[l];
        row_max_lane = LW'(l);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx <= '0;
      max_val <= '0;
      max_vld <= 1'b0;
    end else begin
      if (state == IDLE) max_vld <= 1'b0;
      if (cap_wr && (row_cnt == '0 || row_max_val > max_val)) begin
        max_val <= row_max_val;
        max_idx <= {row_cnt, row_max_lane};
      end
      if (load && idx == '0) max_vld <= 1'b1;
      if (state == SEND && !load && strm.vld && strm.out_rdy && strm.eof) max_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_l4_drain.sv
// tb_l4_drain: directed self-checking bench for l4_drain (default build).
// Layer-4 rows carry base + row*16 + lane so every streamed word is known.
module tb_l4_drain;
  import cnn_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           l4_rdy = 1'b0;
  logic [17:0]    l4_dout [15:0];
  logic           tx_done;
  int unsigned    n_chk = 0;
  int unsigned    n_fail = 0;
  logic           bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  l4_drain_if #(.DW(CNN_DW)) strm ();

  l4_drain #(
    .DW     (CNN_DW),
    .LANES  (L4_LANES),
    .ROWS   (L4_ROWS),
    .RD_LAT (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .l4_rdy  (l4_rdy),
    .l4_dout (l4_dout),
    .tx_done (tx_done),
    .strm    (strm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_row(input logic [17:0] base, input int unsigned r);
    for (int unsigned l = 0; l < 16; l++) l4_dout[l] = base + 18'(r*16 + l);
  endtask

  // Raise l4_rdy; row r is presented for the capture edge T+1+r.
  // Returns just after edge T+4.
  task automatic start_image(input logic [17:0] base);
    @(negedge clk);
    l4_rdy = 1'b1;
    @(posedge clk);
    for (int unsigned r = 0; r < 4; r++) begin
      @(negedge clk);
      set_row(base, r);
      @(posedge clk);
    end
  endtask

  // Drain one image; n counts cycles since the rise edge T (sampled at negedges).
  task automatic run_image(input logic [17:0] base, input logic bp, input logic timing);
    int n = 3;
    int word = 0;
    int first_v = -1;
    int td_n = -1;
    int td_cnt = 0;
    logic held = 1'b0;
    logic [17:0] hd = '0;
    logic hs = 1'b0, he = 1'b0;
    start_image(base);
    forever begin
      @(negedge clk);
      n++;
      strm.out_rdy = bp ? bp_pat[n % 4] : 1'b1;
      if (held) begin
        check("hold_vld", 32'(strm.vld), 32'd1);
        check("hold_dout", 32'(strm.dout), 32'(hd));
        check("hold_sof", 32'(strm.sof), 32'(hs));
        check("hold_eof", 32'(strm.eof), 32'(he));
      end
      held = 1'b0;
      if (strm.vld) begin
        if (first_v < 0) first_v = n;
        if (strm.out_rdy) begin
          check("dout", 32'(strm.dout), 32'(base + 18'(word)));
          check("sof", 32'(strm.sof), 32'(word == 0));
          check("eof", 32'(strm.eof), 32'(word == 63));
          word++;
        end else begin
          held = 1'b1;
          hd = strm.dout;
          hs = strm.sof;
          he = strm.eof;
        end
      end
      if (tx_done) begin
        td_cnt++;
        if (td_n < 0) td_n = n;
      end
      if (td_n >= 0 && n == td_n + 1) l4_rdy = 1'b0;
      if (td_n >= 0 && n >= td_n + 2) break;
      if (n > 600) begin
        check("drain_timeout", 32'd1, 32'd0);
        l4_rdy = 1'b0;
        break;
      end
    end
    check("word_count", 32'(word), 32'd64);
    check("tx_done_count", 32'(td_cnt), 32'd1);
    check("vld_after", 32'(strm.vld), 32'd0);
    if (timing) begin
      check("first_vld_cycle", 32'(first_v), 32'd5);
      check("tx_done_cycle", 32'(td_n), 32'd69);
    end
  endtask

  initial begin
    int vcnt;
    int tcnt;
    logic found;
    strm.out_rdy = 1'b1;
    for (int unsigned l = 0; l < 16; l++) l4_dout[l] = '0;
    #1;
    check("rst_vld", 32'(strm.vld), 32'd0);
    check("rst_sof", 32'(strm.sof), 32'd0);
    check("rst_eof", 32'(strm.eof), 32'd0);
    check("rst_dout", 32'(strm.dout), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic drain
    run_image(18'h0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Backpressure 1,0,0,1
    run_image(18'h100, 1'b1, 1'b0);
    strm.out_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Abort during CAP cycle 2
    @(negedge clk);
    l4_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk); set_row(18'h3000, 0);
    @(posedge clk);
    @(negedge clk); set_row(18'h3000, 1);
    @(posedge clk);
    @(negedge clk); l4_rdy = 1'b0;
    vcnt = 0;
    tcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (strm.vld) vcnt++;
      if (tx_done) tcnt++;
    end
    check("abort_vld", 32'(vcnt), 32'd0);
    check("abort_tx_done", 32'(tcnt), 32'd0);
    run_image(18'h200, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-SEND at word 20
    start_image(18'h2000);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (strm.vld && strm.dout == 18'h2000 + 18'd20) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_word20", 32'(found), 32'd1);
    rst_n = 1'b0;
    l4_rdy = 1'b0;
    #1;
    check("mid_rst_vld", 32'(strm.vld), 32'd0);
    check("mid_rst_tx_done", 32'(tx_done), 32'd0);
    check("mid_rst_dout", 32'(strm.dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    tcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (strm.vld) vcnt++;
      if (tx_done) tcnt++;
    end
    check("post_rst_vld", 32'(vcnt), 32'd0);
    check("post_rst_tx_done", 32'(tcnt), 32'd0);
    run_image(18'h300, 1'b0, 1'b1);

    // Back-to-back: next rise 2 cycles after l4_rdy drops
    run_image(18'h400, 1'b0, 1'b1);
    run_image(18'h500, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
